// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the controller state encoding, the fetch stride and the default
// values for the halt instruction word and the start-of-program address.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Instructions are 16-bit and byte addressed, so sequential fetch steps by 2.
    localparam logic [15:0] PC_STEP           = 16'd2;
    localparam logic [15:0] DEFAULT_HALT_WORD = 16'hEFFF;
    localparam logic [15:0] DEFAULT_RESET_PC  = 16'h0000;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter register with its next-address selection.
// Priority of the next-PC mux: reset, redirect, program (re)start,
// sequential advance, hold.
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset, loads RESET_PC
//   load_reset    - load RESET_PC (start of a program run)
//   load_redirect - load target with bit 0 forced low
//   advance       - step to pc + PC_STEP (wraps at 16 bits)
//   target        - redirect destination
//   pc            - current fetch address
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_reset,
    input  logic        load_redirect,
    input  logic        advance,
    input  logic [15:0] target,
    output logic [15:0] pc
);

    logic [15:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (load_redirect) begin
            // Instructions are halfword aligned; an odd target is rounded down.
            pc_next = {target[15:1], 1'b0};
        end else if (load_reset) begin
            pc_next = RESET_PC;
        end else if (advance) begin
            // 16-bit add wraps FFFE -> 0000 naturally.
            pc_next = pc + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller with a one-entry instruction buffer.
// Fetches from an external combinational instruction memory, hands
// instructions to decode with a valid/ready handshake, follows branch
// redirects and stops after the halt word has been accepted by decode.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start             - pulse that begins a program run from IDLE or HALT
//   programcounter    - fetch address to instruction memory
//   imem_data         - instruction memory read data for programcounter
//   instr, instr_pc   - buffered instruction and its address
//   instr_valid       - buffer holds a valid instruction
//   instr_ready       - decode accepts the buffered instruction
//   redirect          - taken branch: flush buffer, refetch at redirect_target
//   redirect_target   - branch destination
//   halted            - controller is in HALT
//   issue_count       - saturating count of completed handshakes
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [15:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] programcounter,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_target,
    output logic        halted,
    output logic [15:0] issue_count
);

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic        handshake;
    logic        capture;
    logic        flush;
    logic        load_reset;
    logic        load_redirect;
    logic        advance;

    assign handshake      = instr_valid && instr_ready;
    assign programcounter = pc;
    assign halted         = (state == ST_HALT);

    fetch_pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .load_reset    (load_reset),
        .load_redirect (load_redirect),
        .advance       (advance),
        .target        (redirect_target),
        .pc            (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        capture       = 1'b0;
        flush         = 1'b0;
        load_reset    = 1'b0;
        load_redirect = 1'b0;
        advance       = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_next = ST_RUN;
                    load_reset = 1'b1;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    load_redirect = 1'b1;
                    flush         = 1'b1;
                end else if (!instr_valid || instr_ready) begin
                    capture = 1'b1;
                    // The halt word is buffered but pc stays on it; nothing
                    // past it is fetched.
                    if (imem_data == HALT_WORD) begin
                        state_next = ST_DRAIN;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Buffer holds the halt word; wait for decode to take it
                // unless a branch ahead of it cancels the halt.
                if (redirect) begin
                    load_redirect = 1'b1;
                    flush         = 1'b1;
                    state_next    = ST_RUN;
                end else if (handshake) begin
                    flush      = 1'b1;
                    state_next = ST_HALT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
            instr_valid <= 1'b0;
            issue_count <= 16'h0000;
        end else begin
            if (flush) begin
                instr_valid <= 1'b0;
            end else if (capture) begin
                instr       <= imem_data;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end
            // A handshake coinciding with a redirect still counts.
            if (handshake && (issue_count != 16'hFFFF)) begin
                issue_count <= issue_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after start.
REQ-002 SHALL have parameter HALT_WORD, default 16'hEFFF, instruction word that ends fetching.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins fetching from IDLE or HALT.
REQ-006 programcounter  output  16  byte address driven to the instruction memory.
REQ-007 imem_data  input  16  combinational instruction-memory read data for programcounter.
REQ-008 instr  output  16  buffered instruction to decode.
REQ-009 instr_pc  output  16  address instr was fetched from.
REQ-010 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-011 instr_ready  input  1  decode accepts instr this cycle.
REQ-012 redirect  input  1  branch taken; flush and refetch from redirect_target.
REQ-013 redirect_target  input  16  new fetch address.
REQ-014 halted  output  1  high in HALT state.
REQ-015 issue_count  output  16  number of completed instr handshakes since reset, saturating.

Function
REQ-016 SHALL implement four states: IDLE, RUN, DRAIN, HALT.
REQ-017 IDLE: start -> RUN with pc=RESET_PC; all other inputs ignored.
REQ-018 RUN: capture condition = !instr_valid || instr_ready; on capture, instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+2.
REQ-019 RUN: no capture -> pc, instr, instr_pc, instr_valid held (stall).
REQ-020 RUN: capture of imem_data==HALT_WORD -> state DRAIN, pc not incremented.
REQ-021 DRAIN: no further captures; handshake on HALT_WORD -> instr_valid<=0, state HALT.
REQ-022 HALT: halted=1, instr_valid=0; start -> RUN with pc=RESET_PC.
REQ-023 programcounter SHALL equal pc combinationally in every state; throughput one instruction per cycle while instr_ready stays high.
REQ-024 Handshake completes when instr_valid && instr_ready; instr/instr_pc SHALL stay stable while instr_valid && !instr_ready.
REQ-025 Redirect in RUN or DRAIN: pc<={redirect_target[15:1],1'b0}, instr_valid<=0, state RUN; overrides capture that cycle.
REQ-026 Redirect in IDLE or HALT SHALL be ignored; start in RUN or DRAIN SHALL be ignored.
REQ-027 Redirect coincident with a handshake: handshake counts, buffer still flushed.
REQ-028 pc+2 SHALL wrap 16'hFFFE -> 16'h0000.
REQ-029 issue_count SHALL increment on each handshake and saturate at 16'hFFFF.

Reset
REQ-030 rst SHALL force state IDLE, pc=RESET_PC, instr=16'h0000, instr_pc=16'h0000, instr_valid=0, halted=0, issue_count=0.
REQ-031 rst SHALL take priority over start, redirect and handshakes, including mid-RUN or mid-DRAIN.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum, PC_STEP=2 and the default HALT_WORD/RESET_PC constants.
REQ-033 Next-PC mux (reset/start/redirect/increment/hold) SHALL be a sub-module fetch_pc_unit; the instruction memory stays external.

Verification
REQ-034 Reset, start, instr_ready=1, memory 0:f120, 2:f121, 4:EFFF -> instr_pc 0,2,4 on consecutive cycles, then halted=1, issue_count=3.
REQ-035 Stall: instr_ready=0 for 3 cycles with instr=f121 -> instr, instr_pc=2, programcounter=4 held; released -> next instr_pc=4.
REQ-036 Redirect to 16'h001B while instr_valid=1 -> instr_valid=0 next cycle, programcounter=16'h001A, next instr_pc=16'h001A.
REQ-037 HALT_WORD in buffer, redirect before acceptance -> no halt, state RUN, fetch resumes at target.
REQ-038 redirect_target=16'hFFFE -> fetches FFFE then 0000; rst asserted mid-RUN -> all outputs at reset values next cycle.
